operand_b_conditioner: RTL and testbench

- Parametrised, pipelined successor to the ALU B-operand inverter mux.
- Takes a WIDTH-bit B operand plus a 2-bit mode. Produces the conditioned operand and the matching adder carry-in, so subtraction needs no external carry logic.
- Sits between the operand register file and the adder, with valid/ready handshakes on both sides.
- A 2-entry skid buffer keeps full throughput while registering in_ready, which cuts the combinational ready path.

---
 rtl/operand_b_conditioner.sv | 190 +++++++++++++++++++
 tb/tb_operand_b_conditioner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_b_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : operand_b_conditioner
//  Description : Conditions the ALU B operand (pass / subtract / invert /
//                zero) and produces the matching adder carry-in. Valid/ready
//                on both sides, 2-entry skid buffer with a registered in_ready.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_b_conditioner #(
    parameter int WIDTH         = 8,
    parameter bit ZERO_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin
);

    localparam logic [1:0] C_MODE_PASS = 2'b00;
    localparam logic [1:0] C_MODE_SUB  = 2'b01;
    localparam logic [1:0] C_MODE_NOT  = 2'b10;
    localparam logic [1:0] C_MODE_ZERO = 2'b11;

    // Encoding is {main valid, skid valid}; (0,1) is never entered.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_in_ready;

    logic [WIDTH-1:0] r_m_b;
    logic             r_m_cin;
    logic [WIDTH-1:0] r_s_b;
    logic             r_s_cin;

    logic [WIDTH-1:0] w_cond_b;
    logic             w_cond_cin;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_m_in;
    logic             w_load_m_skid;
    logic             w_load_s;

    logic [WIDTH-1:0] w_m_b_next;
    logic             w_m_cin_next;
    logic [WIDTH-1:0] w_s_b_next;
    logic             w_s_cin_next;

    // Mode function on the incoming operand; captured only at acceptance.
    always_comb begin
        w_cond_b   = in_b;
        w_cond_cin = 1'b0;
        case (in_mode)
            C_MODE_PASS: begin
                w_cond_b   = in_b;
                w_cond_cin = 1'b0;
            end
            C_MODE_SUB: begin
                w_cond_b   = ~in_b;
                w_cond_cin = 1'b1;
            end
            C_MODE_NOT: begin
                w_cond_b   = ~in_b;
                w_cond_cin = 1'b0;
            end
            C_MODE_ZERO: begin
                w_cond_b   = '0;
                w_cond_cin = 1'b0;
            end
            default: begin
                w_cond_b   = in_b;
                w_cond_cin = 1'b0;
            end
        endcase
    end

    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & r_in_ready;
    assign w_drain   = out_valid & out_ready;

    // Next-state and register-load decode. in_ready is low in FULL, so an
    // accept can never coincide with FULL.
    always_comb begin
        w_state_next  = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_m_in  = 1'b1;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_m_in = 1'b1;
                end else if (w_accept) begin
                    w_load_s     = 1'b1;
                    w_state_next = ST_FULL;
                end else if (w_drain) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_load_m_skid = 1'b1;
                    w_state_next  = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // Next contents of the main and skid data registers.
    always_comb begin
        w_m_b_next   = r_m_b;
        w_m_cin_next = r_m_cin;
        w_s_b_next   = r_s_b;
        w_s_cin_next = r_s_cin;
        if (w_load_m_in) begin
            w_m_b_next   = w_cond_b;
            w_m_cin_next = w_cond_cin;
        end else if (w_load_m_skid) begin
            w_m_b_next   = r_s_b;
            w_m_cin_next = r_s_cin;
        end
        if (w_load_s) begin
            w_s_b_next   = w_cond_b;
            w_s_cin_next = w_cond_cin;
        end
    end

    // State register and registered in_ready (low only when heading to FULL).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
        end
    end

    generate
        if (ZERO_ON_RESET) begin : g_data_rst
            // Data registers cleared by reset so outputs read zero while idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_m_b   <= '0;
                    r_m_cin <= 1'b0;
                    r_s_b   <= '0;
                    r_s_cin <= 1'b0;
                end else begin
                    r_m_b   <= w_m_b_next;
                    r_m_cin <= w_m_cin_next;
                    r_s_b   <= w_s_b_next;
                    r_s_cin <= w_s_cin_next;
                end
            end
        end else begin : g_data_norst
            // Data registers without reset; only the valid state is cleared.
            always_ff @(posedge clk) begin
                r_m_b   <= w_m_b_next;
                r_m_cin <= w_m_cin_next;
                r_s_b   <= w_s_b_next;
                r_s_cin <= w_s_cin_next;
            end
        end
    endgenerate

    assign in_ready = r_in_ready;
    assign out_b    = r_m_b;
    assign out_cin  = r_m_cin;

endmodule
`default_nettype wire

// File: tb/tb_operand_b_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_operand_b_conditioner
//  Description : Scoreboard bench for operand_b_conditioner, WIDTH=8 with
//                reset-cleared data and WIDTH=1 without data reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_b_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v8, rdy8, ov8, or8, oc8;
    logic [7:0] b8, ob8;
    logic [1:0] m8;

    logic       v1, rdy1, ov1, or1, oc1;
    logic [0:0] b1, ob1;
    logic [1:0] m1;

    int         n_vec = 0;
    int         n_err = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic       stall8, stall1;
    logic [9:0] hold8;
    logic [2:0] hold1;

    always #5 clk = ~clk;

    operand_b_conditioner #(.WIDTH(8), .ZERO_ON_RESET(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(rdy8), .in_b(b8), .in_mode(m8),
        .out_valid(ov8), .out_ready(or8), .out_b(ob8), .out_cin(oc8)
    );

    operand_b_conditioner #(.WIDTH(1), .ZERO_ON_RESET(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(rdy1), .in_b(b1), .in_mode(m1),
        .out_valid(ov1), .out_ready(or1), .out_b(ob1), .out_cin(oc1)
    );

    // Reference mode function: {cin, b}
    function automatic logic [8:0] model8(input logic [7:0] b, input logic [1:0] m);
        case (m)
            2'b00:   return {1'b0, b};
            2'b01:   return {1'b1, ~b};
            2'b10:   return {1'b0, ~b};
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [1:0] model1(input logic [0:0] b, input logic [1:0] m);
        case (m)
            2'b00:   return {1'b0, b};
            2'b01:   return {1'b1, ~b};
            2'b10:   return {1'b0, ~b};
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Evaluate the transfers about to happen at the next rising edge, then
    // advance to just after the following falling edge.
    task automatic step();
        logic [8:0] e8;
        logic [1:0] e1;
        if (stall8) check_value("hold8", {22'd0, ov8, oc8, ob8}, {22'd0, hold8});
        if (stall1) check_value("hold1", {29'd0, ov1, oc1, ob1}, {29'd0, hold1});
        if (v8 && rdy8) q8.push_back(model8(b8, m8));
        if (v1 && rdy1) q1.push_back(model1(b1, m1));
        if (ov8 && or8) begin
            if (q8.size() == 0) check_value("sb8_extra", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                check_value("sb8", {23'd0, oc8, ob8}, {23'd0, e8});
            end
        end
        if (ov1 && or1) begin
            if (q1.size() == 0) check_value("sb1_extra", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check_value("sb1", {30'd0, oc1, ob1}, {30'd0, e1});
            end
        end
        stall8 = ov8 && !or8;
        hold8  = {ov8, oc8, ob8};
        stall1 = ov1 && !or1;
        hold1  = {ov1, oc1, ob1};
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        v8 = 1'b0; b8 = '0; m8 = '0; or8 = 1'b1;
        v1 = 1'b0; b1 = '0; m1 = '0; or1 = 1'b1;
        stall8 = 1'b0; stall1 = 1'b0; hold8 = '0; hold1 = '0;

        // Reset state
        #12;
        check_value("rst_ov8",  {31'd0, ov8},  32'd0);
        check_value("rst_rdy8", {31'd0, rdy8}, 32'd1);
        check_value("rst_ob8",  {24'd0, ob8},  32'd0);
        check_value("rst_oc8",  {31'd0, oc8},  32'd0);
        check_value("rst_ov1",  {31'd0, ov1},  32'd0);
        check_value("rst_rdy1", {31'd0, rdy1}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // PASS, 1-cycle latency, valid drops when nothing follows
        v8 = 1'b1; b8 = 8'h3C; m8 = 2'b00; or8 = 1'b1;
        step();
        v8 = 1'b0;
        check_value("pass_out", {23'd0, ov8, oc8, ob8}, {23'd0, 1'b1, 1'b0, 8'h3C});
        step();
        check_value("pass_drop", {31'd0, ov8}, 32'd0);

        // SUB / NOT / ZERO back-to-back
        v8 = 1'b1; b8 = 8'h3C; m8 = 2'b01;
        step();
        check_value("sub_out", {23'd0, oc8, ob8}, {23'd0, 9'h1C3});
        check_value("sub_add", {24'd0, 8'(8'h50 + ob8 + {7'd0, oc8})}, 32'h14);
        m8 = 2'b10;
        step();
        check_value("not_out", {23'd0, oc8, ob8}, {23'd0, 9'h0C3});
        m8 = 2'b11;
        step();
        check_value("zero_out", {23'd0, oc8, ob8}, 32'd0);
        v8 = 1'b0;
        step();

        // Backpressure
        or8 = 1'b0; v8 = 1'b1; b8 = 8'h11; m8 = 2'b00;
        step();
        check_value("bp_rdy_one", {31'd0, rdy8}, 32'd1);
        check_value("bp_ob_11",   {24'd0, ob8},  32'h11);
        b8 = 8'h22;
        step();
        check_value("bp_rdy_full", {31'd0, rdy8}, 32'd0);
        b8 = 8'h33;
        step();
        check_value("bp_ignored_rdy", {31'd0, rdy8}, 32'd0);
        check_value("bp_hold_11",     {24'd0, ob8},  32'h11);
        or8 = 1'b1;
        step();
        check_value("bp_ob_22",   {24'd0, ob8},  32'h22);
        check_value("bp_rdy_ret", {31'd0, rdy8}, 32'd1);
        step();
        check_value("bp_ob_33", {24'd0, ob8}, 32'h33);
        v8 = 1'b0;
        step();
        check_value("bp_empty", {31'd0, ov8}, 32'd0);

        // Full throughput
        for (int i = 0; i < 16; i++) begin
            v8 = 1'b1; b8 = 8'(i); m8 = 2'b00; or8 = 1'b1;
            step();
            check_value("tp_rdy", {31'd0, rdy8}, 32'd1);
            check_value("tp_out", {23'd0, ov8, ob8}, {23'd0, 1'b1, 8'(i)});
        end
        v8 = 1'b0;
        step();

        // Random stall on both widths
        for (int i = 0; i < 1000; i++) begin
            v8  = 1'($urandom_range(0, 1));
            b8  = 8'($urandom);
            m8  = 2'($urandom);
            or8 = ($urandom_range(0, 3) != 0);
            v1  = 1'($urandom_range(0, 1));
            b1  = 1'($urandom);
            m1  = 2'($urandom);
            or1 = ($urandom_range(0, 3) != 0);
            step();
        end
        v8 = 1'b0; v1 = 1'b0; or8 = 1'b1; or1 = 1'b1;
        repeat (4) step();
        check_value("rand_left8", q8.size(), 32'd0);
        check_value("rand_left1", q1.size(), 32'd0);

        // Asynchronous reset while FULL
        or8 = 1'b0; v8 = 1'b1; b8 = 8'h44; m8 = 2'b00;
        step();
        b8 = 8'h55;
        step();
        v8 = 1'b0;
        check_value("mr_full_rdy", {31'd0, rdy8}, 32'd0);
        check_value("mr_full_ov",  {31'd0, ov8},  32'd1);
        rst_n = 1'b0;
        #1;
        check_value("mr_ov8",  {31'd0, ov8},  32'd0);
        check_value("mr_rdy8", {31'd0, rdy8}, 32'd1);
        check_value("mr_ob8",  {24'd0, ob8},  32'd0);
        q8.delete();
        q1.delete();
        stall8 = 1'b0;
        stall1 = 1'b0;
        step();
        rst_n = 1'b1;
        or8 = 1'b1;
        repeat (3) step();
        check_value("mr_no_stale", {31'd0, ov8}, 32'd0);
        v8 = 1'b1; b8 = 8'hA5; m8 = 2'b01;
        step();
        v8 = 1'b0;
        check_value("mr_after", {23'd0, ov8, oc8, ob8}, {23'd0, 1'b1, 1'b1, 8'h5A});
        step();
        check_value("mr_done", {31'd0, ov8}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
